// File: rtl/difftest_step_batcher.sv
// Batches per-cycle commit counts into step pulses for the difftest endpoint and drains them before exposing the exit code.
// Optional DIFFTEST_STEP_BATCH_STATS_EN adds saturating counters stat_batches / stat_timeouts.
module difftest_step_batcher #(
    parameter int STEP_W  = 8,
    parameter int CNT_W   = 4,
    parameter int BATCH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_commit_valid,
    input  logic [CNT_W-1:0]  in_commit_cnt,
    input  logic [63:0]       in_exit,
    output logic [STEP_W-1:0] difftest_step,
    output logic [63:0]       difftest_exit
`ifdef DIFFTEST_STEP_BATCH_STATS_EN
    ,
    output logic [31:0]       stat_batches,
    output logic [31:0]       stat_timeouts
`endif
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST    = IDLE_W'(TIMEOUT - 1);
    localparam logic [STEP_W+1:0] BATCH_V      = (STEP_W + 2)'(BATCH);
    localparam logic [STEP_W:0]   STEP_MAX_ACC = {1'b0, {STEP_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_EXITED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W:0]     acc_q, acc_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [63:0]         exit_q, exit_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [63:0]         exit_out_q, exit_out_d;

    logic [STEP_W+1:0]   commit_add;
    logic [STEP_W+1:0]   sum;
    logic [STEP_W:0]     emit_full;
    logic                emit;
    logic                timeout_emit;
    logic                batch_hit;
    logic                timeout_hit;
    logic [STEP_W:0]     acc_after;

    assign commit_add = in_commit_valid ? (STEP_W + 2)'(in_commit_cnt) : '0;
    assign sum        = {1'b0, acc_q} + commit_add;
    // Saturate the pulse at the step width; whatever exceeds it stays in acc.
    assign emit_full  = (sum > {1'b0, STEP_MAX_ACC}) ? STEP_MAX_ACC : sum[STEP_W:0];

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        idle_d       = idle_q;
        step_d       = '0;
        exit_out_d   = exit_out_q;
        emit         = 1'b0;
        timeout_emit = 1'b0;
        batch_hit    = 1'b0;
        timeout_hit  = 1'b0;
        acc_after    = sum[STEP_W:0];
        exit_d       = ((exit_q == 64'd0) && (in_exit != 64'd0)) ? in_exit : exit_q;

        unique case (state_q)
            ST_RUN: begin
                batch_hit   = (sum >= BATCH_V);
                timeout_hit = !in_commit_valid && (idle_q == IDLE_LAST) && (sum != '0);
                if (batch_hit || timeout_hit) begin
                    emit         = 1'b1;
                    timeout_emit = !batch_hit;
                    idle_d       = '0;
                end else if (in_commit_valid || (acc_q == '0)) begin
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
                if (emit) begin
                    acc_after = sum[STEP_W:0] - emit_full;
                end
                acc_d = acc_after;
                if ((exit_q != 64'd0) || (in_exit != 64'd0)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                emit   = (sum != '0);
                idle_d = '0;
                if (emit) begin
                    acc_after = sum[STEP_W:0] - emit_full;
                end
                acc_d = acc_after;
                if (acc_after == '0) begin
                    state_d = ST_EXITED;
                end
                // Nothing left to drain: the exit code can go out on this edge.
                if (sum == '0) begin
                    exit_out_d = exit_q;
                end
            end
            ST_EXITED: begin
                exit_out_d = exit_q;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (emit) begin
            step_d = emit_full[STEP_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RUN;
            acc_q      <= '0;
            idle_q     <= '0;
            exit_q     <= '0;
            step_q     <= '0;
            exit_out_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            idle_q     <= idle_d;
            exit_q     <= exit_d;
            step_q     <= step_d;
            exit_out_q <= exit_out_d;
        end
    end

    assign difftest_step = step_q;
    assign difftest_exit = exit_out_q;

`ifdef DIFFTEST_STEP_BATCH_STATS_EN
    logic [31:0] batches_q, batches_d;
    logic [31:0] timeouts_q, timeouts_d;

    always_comb begin
        batches_d  = batches_q;
        timeouts_d = timeouts_q;
        if (emit && (batches_q != 32'hFFFF_FFFF)) begin
            batches_d = batches_q + 32'd1;
        end
        if (timeout_emit && (timeouts_q != 32'hFFFF_FFFF)) begin
            timeouts_d = timeouts_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            batches_q  <= '0;
            timeouts_q <= '0;
        end else begin
            batches_q  <= batches_d;
            timeouts_q <= timeouts_d;
        end
    end

    assign stat_batches  = batches_q;
    assign stat_timeouts = timeouts_q;
`endif

endmodule

// File: tb/tb_difftest_step_batcher.sv
// Directed bench for difftest_step_batcher: a default instance plus a narrow 4-bit-step instance for saturation.
module tb_difftest_step_batcher;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid;
    logic [3:0]  cnt;
    logic [63:0] in_exit;
    logic [7:0]  step;
    logic [63:0] dexit;

    logic        s_valid;
    logic [3:0]  s_cnt;
    logic [63:0] s_in_exit;
    logic [3:0]  s_step;
    logic [63:0] s_dexit;

    int total = 0;
    int bad   = 0;

`ifdef DIFFTEST_STEP_BATCH_STATS_EN
    logic [31:0] st_batches, st_timeouts, s_st_batches, s_st_timeouts;
`endif

    always #5 clock = ~clock;

    difftest_step_batcher #(.STEP_W(8), .CNT_W(4), .BATCH(16), .TIMEOUT(64)) dut (
        .clock           (clock),
        .reset           (reset),
        .in_commit_valid (valid),
        .in_commit_cnt   (cnt),
        .in_exit         (in_exit),
        .difftest_step   (step),
        .difftest_exit   (dexit)
`ifdef DIFFTEST_STEP_BATCH_STATS_EN
        ,
        .stat_batches    (st_batches),
        .stat_timeouts   (st_timeouts)
`endif
    );

    difftest_step_batcher #(.STEP_W(4), .CNT_W(4), .BATCH(15), .TIMEOUT(8)) dut_s (
        .clock           (clock),
        .reset           (reset),
        .in_commit_valid (s_valid),
        .in_commit_cnt   (s_cnt),
        .in_exit         (s_in_exit),
        .difftest_step   (s_step),
        .difftest_exit   (s_dexit)
`ifdef DIFFTEST_STEP_BATCH_STATS_EN
        ,
        .stat_batches    (s_st_batches),
        .stat_timeouts   (s_st_timeouts)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; valid = 1'b0; cnt = '0; in_exit = '0;
        s_valid = 1'b0; s_cnt = '0; s_in_exit = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (step !== 8'd0 || dexit !== 64'd0) begin
            bad++; $display("FAIL reset_main: step=%0d exit=%h, required 0/0", step, dexit);
        end
        total++;
        if (s_step !== 4'd0 || s_dexit !== 64'd0) begin
            bad++; $display("FAIL reset_narrow: step=%0d exit=%h, required 0/0", s_step, s_dexit);
        end
        $display("test_reset: step=%0d exit=%h", step, dexit);
    endtask

    task automatic test_batch();
        int pulses;
        valid = 1'b1; cnt = 4'd4;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++;
            if (step !== ((i == 4) ? 8'd16 : 8'd0)) begin
                bad++; $display("FAIL batch_step%0d: got %0d, required %0d", i, step, (i == 4) ? 16 : 0);
            end
        end
        valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (step !== 8'd0) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++; $display("FAIL batch_leftover: got %0d extra pulses, required 0", pulses);
        end
        $display("test_batch: 4x4 -> 16, extra pulses=%0d", pulses);
    endtask

    task automatic test_timeout();
        int early;
        valid = 1'b1; cnt = 4'd3;
        tick();
        valid = 1'b0;
        early = 0;
        for (int i = 1; i <= 63; i++) begin
            tick();
            if (step !== 8'd0) early++;
        end
        total++;
        if (early != 0) begin
            bad++; $display("FAIL timeout_early: got %0d early pulses, required 0", early);
        end
        tick();
        total++;
        if (step !== 8'd3) begin
            bad++; $display("FAIL timeout_emit: got %0d, required 3", step);
        end
        tick();
        total++;
        if (step !== 8'd0) begin
            bad++; $display("FAIL timeout_pulse_len: got %0d, required 0", step);
        end
`ifdef DIFFTEST_STEP_BATCH_STATS_EN
        total++;
        if (st_batches !== 32'd2 || st_timeouts !== 32'd1) begin
            bad++; $display("FAIL stats: batches=%0d timeouts=%0d, required 2/1", st_batches, st_timeouts);
        end
`endif
        $display("test_timeout: cnt=3 emitted after 64 idle edges, step=%0d", step);
    endtask

    task automatic test_saturation();
        s_valid = 1'b1; s_cnt = 4'd15;
        tick();
        total++;
        if (s_step !== 4'd15) begin bad++; $display("FAIL sat_a: got %0d, required 15", s_step); end
        tick();
        total++;
        if (s_step !== 4'd15) begin bad++; $display("FAIL sat_b: got %0d, required 15", s_step); end
        tick();
        total++;
        if (s_step !== 4'd15) begin bad++; $display("FAIL sat_c: got %0d, required 15", s_step); end
        s_cnt = 4'd1;
        tick();
        total++;
        if (s_step !== 4'd0) begin bad++; $display("FAIL sat_hold1: got %0d, required 0", s_step); end
        s_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if (s_step !== ((i == 8) ? 4'd1 : 4'd0)) begin
                bad++; $display("FAIL sat_rem1_%0d: got %0d, required %0d", i, s_step, (i == 8) ? 1 : 0);
            end
        end
        // 10 + 15 = 25 exceeds the 4-bit step: 15 now, 10 kept for the timeout.
        s_valid = 1'b1; s_cnt = 4'd10;
        tick();
        s_cnt = 4'd15;
        tick();
        total++;
        if (s_step !== 4'd15) begin bad++; $display("FAIL sat_clip: got %0d, required 15", s_step); end
        s_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if (s_step !== ((i == 8) ? 4'd10 : 4'd0)) begin
                bad++; $display("FAIL sat_rem10_%0d: got %0d, required %0d", i, s_step, (i == 8) ? 10 : 0);
            end
        end
        $display("test_saturation: 15,15,15 then remainders 1 and 10 via timeout");
    endtask

    task automatic test_exit_drain();
        valid = 1'b1; cnt = 4'd5;
        tick();
        valid = 1'b0; in_exit = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        total++;
        if (step !== 8'd0 || dexit !== 64'd0) begin
            bad++; $display("FAIL drain_enter: step=%0d exit=%h, required 0/0", step, dexit);
        end
        tick();
        total++;
        if (step !== 8'd5 || dexit !== 64'd0) begin
            bad++; $display("FAIL drain_step: step=%0d exit=%h, required 5/0", step, dexit);
        end
        tick();
        total++;
        if (step !== 8'd0 || dexit !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            bad++; $display("FAIL drain_exit: step=%0d exit=%h, required 0/ffffffffffffffff", step, dexit);
        end
        in_exit = 64'd0; valid = 1'b1; cnt = 4'd15;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (step !== 8'd0 || dexit !== 64'hFFFF_FFFF_FFFF_FFFF) begin
                bad++; $display("FAIL drain_hold%0d: step=%0d exit=%h, required 0/ffffffffffffffff", i, step, dexit);
            end
        end
        valid = 1'b0;
        $display("test_exit_drain: step 5 then exit all-ones held");
    endtask

    task automatic test_first_wins();
        do_reset();
        valid = 1'b1; cnt = 4'd2; in_exit = 64'h3;
        tick();
        total++;
        if (step !== 8'd0 || dexit !== 64'd0) begin
            bad++; $display("FAIL first_c0: step=%0d exit=%h, required 0/0", step, dexit);
        end
        valid = 1'b0; in_exit = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        total++;
        if (step !== 8'd2 || dexit !== 64'd0) begin
            bad++; $display("FAIL first_c1: step=%0d exit=%h, required 2/0", step, dexit);
        end
        tick();
        total++;
        if (step !== 8'd0 || dexit !== 64'h3) begin
            bad++; $display("FAIL first_c2: step=%0d exit=%h, required 0/3", step, dexit);
        end
        tick();
        total++;
        if (dexit !== 64'h3) begin
            bad++; $display("FAIL first_hold: exit=%h, required 3", dexit);
        end
        $display("test_first_wins: step 2 then exit=%h", dexit);
    endtask

    task automatic test_exit_idle();
        do_reset();
        in_exit = 64'h9;
        tick();
        total++;
        if (dexit !== 64'd0) begin
            bad++; $display("FAIL idle_exit_c1: exit=%h, required 0", dexit);
        end
        in_exit = 64'd0;
        tick();
        total++;
        if (dexit !== 64'h9 || step !== 8'd0) begin
            bad++; $display("FAIL idle_exit_c2: step=%0d exit=%h, required 0/9", step, dexit);
        end
        $display("test_exit_idle: exit=%h two cycles after in_exit", dexit);
    endtask

    task automatic test_reset_flush();
        do_reset();
        valid = 1'b1; cnt = 4'd7;
        tick();
        valid = 1'b0; in_exit = 64'h5;
        tick();
        reset = 1'b1;
        tick();
        total++;
        if (step !== 8'd0 || dexit !== 64'd0) begin
            bad++; $display("FAIL rflush_reset: step=%0d exit=%h, required 0/0", step, dexit);
        end
        reset = 1'b0; in_exit = 64'd0;
        tick();
        total++;
        if (step !== 8'd0 || dexit !== 64'd0) begin
            bad++; $display("FAIL rflush_after: step=%0d exit=%h, required 0/0", step, dexit);
        end
        valid = 1'b1; cnt = 4'd15;
        tick();
        cnt = 4'd1;
        tick();
        total++;
        if (step !== 8'd16 || dexit !== 64'd0) begin
            bad++; $display("FAIL rflush_batch: step=%0d exit=%h, required 16/0", step, dexit);
        end
        valid = 1'b0;
        tick();
        total++;
        if (step !== 8'd0 || dexit !== 64'd0) begin
            bad++; $display("FAIL rflush_tail: step=%0d exit=%h, required 0/0", step, dexit);
        end
        $display("test_reset_flush: acc discarded, later batch 16, exit=%h", dexit);
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; cnt = '0; in_exit = '0;
        s_valid = 1'b0; s_cnt = '0; s_in_exit = '0;
        test_reset();
        test_batch();
        test_timeout();
        test_saturation();
        test_exit_drain();
        test_first_wins();
        test_exit_idle();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
